// File: rtl/jtgng_sdram_resp.sv
// Behavioral SDRAM responder: decodes controller commands, tracks per-bank open rows,
// runs read/write bursts with the programmed CL/BL and flags protocol violations.
module jtgng_sdram_resp #(
    parameter int MEMW = 16,
    parameter int TRCD = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sdram_cke,
    input  logic        sdram_ncs,
    input  logic        sdram_nras,
    input  logic        sdram_ncas,
    input  logic        sdram_nwe,
    input  logic [12:0] sdram_a,
    input  logic [1:0]  sdram_ba,
    input  logic        sdram_dqml,
    input  logic        sdram_dqmh,
    input  logic [15:0] dq_in,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    output logic [12:0] mode_reg,
    output logic        err,
    output logic [2:0]  err_code,
    output logic [15:0] refresh_cnt
);
    typedef enum logic [2:0] {
        C_LMR = 3'b000, C_REF = 3'b001, C_PRE  = 3'b010, C_ACT = 3'b011,
        C_WR  = 3'b100, C_RD  = 3'b101, C_STOP = 3'b110, C_NOP = 3'b111
    } cmd_e;

    localparam logic [7:0] TRCD_C = 8'(TRCD);

    cmd_e cmd;
    logic cmd_ok;
    assign cmd_ok = sdram_cke & ~sdram_ncs;
    assign cmd    = cmd_e'({sdram_nras, sdram_ncas, sdram_nwe});

    logic [3:0]       bank_open;
    logic [3:0][12:0] bank_row;
    logic [3:0][7:0]  act_cnt;   // edges since ACTIVATE, saturating

    logic        burst_active, burst_wr, burst_ap, burst_cl3;
    logic [1:0]  burst_bank;
    logic [12:0] burst_row;
    logic [8:0]  burst_col, burst_mask;
    logic [3:0]  burst_rem;
    logic        ap_close;
    logic [1:0]  ap_bank;

    logic        p0_vld, p0_cl3, p1_vld;
    logic [15:0] p1_data, rd_data;

    logic        bl_ok, cl_ok;
    logic [3:0]  bl_len;
    logic [8:0]  bl_mask;
    assign bl_ok   = ~mode_reg[2];
    assign cl_ok   = (mode_reg[6:4] == 3'd2) || (mode_reg[6:4] == 3'd3);
    assign bl_len  = 4'd1 << mode_reg[1:0];
    assign bl_mask = {5'd0, bl_len - 4'd1};

    logic [2:0]  rw_code;
    logic        rw_go, kill, word_go;
    logic        w_wr, w_ap, w_cl3;
    logic [1:0]  w_bank;
    logic [12:0] w_row;
    logic [8:0]  w_col, w_mask, col_nxt;
    logic [3:0]  w_left;

    // The word handled on this edge comes either from a freshly accepted
    // READ/WRITE or from the running burst.
    always_comb begin
        rw_code = 3'd0;
        if (!bank_open[sdram_ba])             rw_code = 3'd2;
        else if (act_cnt[sdram_ba] < TRCD_C) rw_code = 3'd3;
        else if (!bl_ok || !cl_ok)           rw_code = 3'd5;
        rw_go   = cmd_ok && (cmd == C_RD || cmd == C_WR) && (rw_code == 3'd0);
        kill    = burst_active && cmd_ok &&
                  (cmd == C_STOP || (cmd == C_PRE && (sdram_a[10] || sdram_ba == burst_bank)));
        word_go = rw_go || (burst_active && !kill);
        if (rw_go) begin
            w_wr   = (cmd == C_WR);
            w_bank = sdram_ba;
            w_row  = bank_row[sdram_ba];
            w_col  = sdram_a[8:0];
            w_mask = bl_mask;
            w_left = bl_len - 4'd1;
            w_ap   = sdram_a[10];
            w_cl3  = mode_reg[4];
        end else begin
            w_wr   = burst_wr;
            w_bank = burst_bank;
            w_row  = burst_row;
            w_col  = burst_col;
            w_mask = burst_mask;
            w_left = burst_rem - 4'd1;
            w_ap   = burst_ap;
            w_cl3  = burst_cl3;
        end
        col_nxt = (w_col & ~w_mask) | ((w_col + 9'd1) & w_mask);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_open    <= '0;
            bank_row     <= '0;
            act_cnt      <= '0;
            burst_active <= 1'b0;
            burst_wr     <= 1'b0;
            burst_ap     <= 1'b0;
            burst_cl3    <= 1'b0;
            burst_bank   <= '0;
            burst_row    <= '0;
            burst_col    <= '0;
            burst_mask   <= '0;
            burst_rem    <= '0;
            ap_close     <= 1'b0;
            ap_bank      <= '0;
            p0_vld       <= 1'b0;
            p0_cl3       <= 1'b0;
            p1_vld       <= 1'b0;
            p1_data      <= '0;
            dq_out       <= '0;
            dq_oe        <= 1'b0;
            mode_reg     <= '0;
            err          <= 1'b0;
            err_code     <= '0;
            refresh_cnt  <= '0;
        end else begin
            err      <= 1'b0;
            ap_close <= 1'b0;
            for (int b = 0; b < 4; b++)
                if (act_cnt[b] != 8'hFF) act_cnt[b] <= act_cnt[b] + 8'd1;
            if (ap_close) bank_open[ap_bank] <= 1'b0;

            if (cmd_ok) begin
                case (cmd)
                    C_ACT: begin
                        if (bank_open[sdram_ba]) begin
                            err <= 1'b1; err_code <= 3'd1;
                        end else begin
                            bank_open[sdram_ba] <= 1'b1;
                            bank_row[sdram_ba]  <= sdram_a;
                            act_cnt[sdram_ba]   <= 8'd1;
                        end
                    end
                    C_RD, C_WR: if (rw_code != 3'd0) begin
                        err <= 1'b1; err_code <= rw_code;
                    end
                    C_PRE: begin
                        if (sdram_a[10]) bank_open <= '0;
                        else             bank_open[sdram_ba] <= 1'b0;
                    end
                    C_REF: begin
                        if (|bank_open) begin err <= 1'b1; err_code <= 3'd4; end
                        else            refresh_cnt <= refresh_cnt + 16'd1;
                    end
                    C_LMR: begin
                        if (|bank_open) begin err <= 1'b1; err_code <= 3'd4; end
                        else            mode_reg <= sdram_a;
                    end
                    default: ;
                endcase
            end

            if (word_go) begin
                burst_active <= (w_left != 4'd0);
                burst_rem    <= w_left;
                burst_col    <= col_nxt;
                if (rw_go) begin
                    burst_wr   <= w_wr;
                    burst_bank <= w_bank;
                    burst_row  <= w_row;
                    burst_mask <= w_mask;
                    burst_ap   <= w_ap;
                    burst_cl3  <= w_cl3;
                end
                if (w_left == 4'd0 && w_ap) begin
                    ap_close <= 1'b1;
                    ap_bank  <= w_bank;
                end
            end else if (kill) begin
                burst_active <= 1'b0;
            end

            // Each fetched word carries its own CL so later mode loads cannot retime it.
            p0_vld  <= word_go && !w_wr;
            p0_cl3  <= w_cl3;
            p1_vld  <= p0_vld && p0_cl3;
            p1_data <= rd_data;
            if (p1_vld) begin
                dq_oe <= 1'b1; dq_out <= p1_data;
            end else if (p0_vld && !p0_cl3) begin
                dq_oe <= 1'b1; dq_out <= rd_data;
            end else begin
                dq_oe <= 1'b0; dq_out <= '0;
            end
        end
    end

    // Storage is deliberately outside the reset domain.
    logic [15:0]     mem [0:(1<<MEMW)-1];
    logic [MEMW-1:0] m_addr;
    assign m_addr = MEMW'({w_bank, w_row, w_col});

    always_ff @(posedge clk) begin
        if (word_go && w_wr) begin
            if (!sdram_dqml) mem[m_addr][7:0]  <= dq_in[7:0];
            if (!sdram_dqmh) mem[m_addr][15:8] <= dq_in[15:8];
        end
        rd_data <= mem[m_addr];
    end
endmodule

// File: tb/tb_jtgng_sdram_resp.sv
// Scenario bench for jtgng_sdram_resp: commands driven on falling edges, read data
// checked against a timed scoreboard, status outputs checked inline per scenario.
module tb_jtgng_sdram_resp;
    localparam logic [3:0] LMR = 4'b0000, REF = 4'b0001, PRE = 4'b0010, ACT = 4'b0011,
                           WR = 4'b0100, RD = 4'b0101, STP = 4'b0110, NOP = 4'b0111;

    logic        clk = 1'b0, rst = 1'b1, cke = 1'b1;
    logic        ncs = 1'b0, nras = 1'b1, ncas = 1'b1, nwe = 1'b1;
    logic [12:0] sdram_a = '0;
    logic [1:0]  sdram_ba = '0;
    logic        dqml = 1'b0, dqmh = 1'b0;
    logic [15:0] dq_in = '0;
    logic [15:0] dq_out, refresh_cnt;
    logic        dq_oe, err;
    logic [12:0] mode_reg;
    logic [2:0]  err_code;

    jtgng_sdram_resp #(.MEMW(16), .TRCD(2)) dut (
        .clk(clk), .rst(rst), .sdram_cke(cke), .sdram_ncs(ncs), .sdram_nras(nras),
        .sdram_ncas(ncas), .sdram_nwe(nwe), .sdram_a(sdram_a), .sdram_ba(sdram_ba),
        .sdram_dqml(dqml), .sdram_dqmh(dqmh), .dq_in(dq_in), .dq_out(dq_out),
        .dq_oe(dq_oe), .mode_reg(mode_reg), .err(err), .err_code(err_code),
        .refresh_cnt(refresh_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0, n_bad = 0;
    typedef struct { logic [15:0] data; int due; } rd_t;
    rd_t sb[$];

    // Scoreboard consumer: every driven read word must match data and edge.
    always @(negedge clk) begin
        rd_t ex;
        if (!rst) begin
            if (dq_oe) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL rd_unexpected cyc %0d got %h expected no read data", cyc, dq_out);
                end else begin
                    ex = sb.pop_front();
                    if (dq_out !== ex.data || cyc != ex.due) begin
                        n_bad++;
                        $display("FAIL rd_word got %h@%0d expected %h@%0d", dq_out, cyc, ex.data, ex.due);
                    end
                end
            end else if (sb.size() != 0 && sb[0].due <= cyc) begin
                n_vec++; n_bad++;
                $display("FAIL rd_missing cyc %0d got dq_oe=0 expected %h@%0d", cyc, sb[0].data, sb[0].due);
                void'(sb.pop_front());
            end
        end
    end

    // Drive one command for one rising edge; returns on the following falling edge.
    task automatic cmd(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a);
        {ncs, nras, ncas, nwe} = c;
        sdram_ba = ba;
        sdram_a  = a;
        @(negedge clk);
        {ncs, nras, ncas, nwe} = NOP;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_vec++; if (dq_oe !== 1'b0 || dq_out !== 16'h0) begin n_bad++; $display("FAIL reset_dq got oe=%b dq=%h expected 0/0000", dq_oe, dq_out); end
        n_vec++; if (mode_reg !== 13'h0 || refresh_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_regs got mode=%h ref=%h expected 0", mode_reg, refresh_cnt); end
        n_vec++; if (err !== 1'b0 || err_code !== 3'd0) begin n_bad++; $display("FAIL reset_err got %b/%0d expected 0/0", err, err_code); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_burst_wrap;
        int e;
        cmd(LMR, 2'd0, 13'h0021);
        n_vec++; if (mode_reg !== 13'h0021) begin n_bad++; $display("FAIL lmr got %h expected 0021", mode_reg); end
        cmd(ACT, 2'd0, 13'd5);
        cmd(NOP, 2'd0, 13'd0);
        dq_in = 16'hA55A; cmd(WR, 2'd0, 13'd3);
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL wr_err got %b expected 0", err); end
        dq_in = 16'h1234; cmd(NOP, 2'd0, 13'd0);
        cmd(RD, 2'd0, 13'd3); e = cyc;
        sb.push_back('{16'hA55A, e + 1}); sb.push_back('{16'h1234, e + 2});
        repeat (2) cmd(NOP, 2'd0, 13'd0);
        cmd(RD, 2'd0, 13'd2); e = cyc;
        sb.push_back('{16'h1234, e + 1}); sb.push_back('{16'hA55A, e + 2});
        repeat (3) cmd(NOP, 2'd0, 13'd0);
    endtask

    task automatic test_byte_mask;
        int e;
        cmd(PRE, 2'd0, 13'h0400);
        cmd(LMR, 2'd0, 13'h0020);
        cmd(ACT, 2'd1, 13'd7);
        cmd(NOP, 2'd0, 13'd0);
        dq_in = 16'h0000; cmd(WR, 2'd1, 13'd0); cmd(WR, 2'd1, 13'd1);
        dq_in = 16'hBEEF; dqmh = 1'b1; cmd(WR, 2'd1, 13'd0);
        dqmh = 1'b0; dqml = 1'b1; cmd(WR, 2'd1, 13'd1);
        dqml = 1'b0;
        cmd(RD, 2'd1, 13'd0); e = cyc; sb.push_back('{16'h00EF, e + 1});
        cmd(RD, 2'd1, 13'd1); e = cyc; sb.push_back('{16'hBE00, e + 1});
        repeat (3) cmd(NOP, 2'd0, 13'd0);
    endtask

    task automatic test_trcd;
        cmd(ACT, 2'd2, 13'd1);
        cmd(RD, 2'd2, 13'd0);
        n_vec++; if (err !== 1'b1 || err_code !== 3'd3) begin n_bad++; $display("FAIL trcd got %b/%0d expected 1/3", err, err_code); end
        cmd(NOP, 2'd0, 13'd0);
        n_vec++; if (err !== 1'b0 || err_code !== 3'd3) begin n_bad++; $display("FAIL err_pulse got %b/%0d expected 0/3", err, err_code); end
        repeat (3) cmd(NOP, 2'd0, 13'd0);
        n_vec++; if (dq_oe !== 1'b0) begin n_bad++; $display("FAIL trcd_no_read got oe=%b expected 0", dq_oe); end
        cmd(ACT, 2'd2, 13'd1);
        n_vec++; if (err !== 1'b1 || err_code !== 3'd1) begin n_bad++; $display("FAIL act_open got %b/%0d expected 1/1", err, err_code); end
    endtask

    task automatic test_refresh;
        cmd(ACT, 2'd0, 13'd0);
        cmd(REF, 2'd0, 13'd0);
        n_vec++; if (err !== 1'b1 || err_code !== 3'd4 || refresh_cnt !== 16'd0) begin n_bad++; $display("FAIL ref_open got %b/%0d cnt=%0d expected 1/4 cnt=0", err, err_code, refresh_cnt); end
        cmd(LMR, 2'd0, 13'h0022);
        n_vec++; if (err_code !== 3'd4 || mode_reg !== 13'h0020) begin n_bad++; $display("FAIL lmr_open got %0d mode=%h expected 4 mode=0020", err_code, mode_reg); end
        cmd(PRE, 2'd0, 13'h0400);
        cmd(REF, 2'd0, 13'd0);
        n_vec++; if (err !== 1'b0 || refresh_cnt !== 16'd1) begin n_bad++; $display("FAIL ref_ok got err=%b cnt=%0d expected 0/1", err, refresh_cnt); end
        cmd(RD, 2'd0, 13'd0);
        n_vec++; if (err !== 1'b1 || err_code !== 3'd2) begin n_bad++; $display("FAIL rd_idle got %b/%0d expected 1/2", err, err_code); end
    endtask

    task automatic test_back_to_back;
        int e;
        cmd(LMR, 2'd0, 13'h0022);
        cmd(ACT, 2'd0, 13'd6);
        cmd(NOP, 2'd0, 13'd0);
        dq_in = 16'h0101; cmd(WR, 2'd0, 13'd0);
        dq_in = 16'h0202; cmd(NOP, 2'd0, 13'd0);
        dq_in = 16'h0303; cmd(NOP, 2'd0, 13'd0);
        dq_in = 16'h0404; cmd(NOP, 2'd0, 13'd0);
        // Second READ one edge later cuts the first burst after one word.
        cmd(RD, 2'd0, 13'd0); e = cyc; sb.push_back('{16'h0101, e + 1});
        cmd(RD, 2'd0, 13'd2); e = cyc;
        sb.push_back('{16'h0303, e + 1}); sb.push_back('{16'h0404, e + 2});
        sb.push_back('{16'h0101, e + 3}); sb.push_back('{16'h0202, e + 4});
        repeat (5) cmd(NOP, 2'd0, 13'd0);
        cmd(RD, 2'd0, 13'd0); e = cyc;
        sb.push_back('{16'h0101, e + 1}); sb.push_back('{16'h0202, e + 2});
        cmd(NOP, 2'd0, 13'd0);
        cmd(STP, 2'd0, 13'd0);
        repeat (4) cmd(NOP, 2'd0, 13'd0);
    endtask

    task automatic test_autoprecharge;
        int e;
        cmd(PRE, 2'd0, 13'h0400);
        cmd(LMR, 2'd0, 13'h0032);
        cmd(ACT, 2'd3, 13'd9);
        cmd(NOP, 2'd0, 13'd0);
        dq_in = 16'h1111; cmd(WR, 2'd3, 13'd4);
        dq_in = 16'h2222; cmd(NOP, 2'd0, 13'd0);
        dq_in = 16'h3333; cmd(NOP, 2'd0, 13'd0);
        dq_in = 16'h4444; cmd(NOP, 2'd0, 13'd0);
        cmd(RD, 2'd3, 13'h0406); e = cyc;
        sb.push_back('{16'h3333, e + 2}); sb.push_back('{16'h4444, e + 3});
        sb.push_back('{16'h1111, e + 4}); sb.push_back('{16'h2222, e + 5});
        repeat (5) cmd(NOP, 2'd0, 13'd0);
        cmd(ACT, 2'd3, 13'd9);
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL ap_idle got err=%b/%0d expected 0", err, err_code); end
        cmd(ACT, 2'd3, 13'd9);
        n_vec++; if (err !== 1'b1 || err_code !== 3'd1) begin n_bad++; $display("FAIL ap_reopen got %b/%0d expected 1/1", err, err_code); end
    endtask

    task automatic test_reset_midburst;
        int e;
        cmd(PRE, 2'd0, 13'h0400);
        cmd(LMR, 2'd0, 13'h0023);
        cmd(ACT, 2'd0, 13'd6);
        cmd(NOP, 2'd0, 13'd0);
        cmd(RD, 2'd0, 13'd0); e = cyc;
        sb.push_back('{16'h0101, e + 1}); sb.push_back('{16'h0202, e + 2});
        repeat (2) cmd(NOP, 2'd0, 13'd0);
        n_vec++; if (dq_oe !== 1'b1) begin n_bad++; $display("FAIL bl8_active got oe=%b expected 1", dq_oe); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if (dq_oe !== 1'b0 || dq_out !== 16'h0) begin n_bad++; $display("FAIL rst_mid got oe=%b dq=%h expected 0/0000", dq_oe, dq_out); end
        n_vec++; if (mode_reg !== 13'h0 || refresh_cnt !== 16'h0 || err_code !== 3'd0) begin n_bad++; $display("FAIL rst_mid_regs got mode=%h ref=%0d code=%0d expected 0", mode_reg, refresh_cnt, err_code); end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        cmd(RD, 2'd0, 13'd0);
        n_vec++; if (err !== 1'b1 || err_code !== 3'd2) begin n_bad++; $display("FAIL rd_after_rst got %b/%0d expected 1/2", err, err_code); end
        repeat (3) cmd(NOP, 2'd0, 13'd0);
    endtask

    initial begin
        test_reset;
        test_burst_wrap;
        test_byte_mask;
        test_trcd;
        test_refresh;
        test_back_to_back;
        test_autoprecharge;
        test_reset_midburst;
        n_vec++; if (sb.size() != 0) begin n_bad++; $display("FAIL sb_drain got %0d pending expected 0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/jtgng_sdram_resp.md
JTGNG_SDRAM_RESP -- requirements
Module: jtgng_sdram_resp

Interface
REQ-001 Parameter MEMW, default 16, meaning: storage depth is 2^MEMW 16-bit words.
REQ-002 Parameter TRCD, default 2, meaning: minimum number of clk edges from ACTIVATE to READ/WRITE on the same bank.
REQ-003 Port clk  in  1  clock; all command sampling on its rising edge.
REQ-004 Port rst  in  1  reset; asynchronous, active-high.
REQ-005 Port sdram_cke  in  1  clock enable; commands are ignored while low.
REQ-006 Port sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe  in  1 each  command bits; {nCS,nRAS,nCAS,nWE} is LOAD_MODE=0000, REFRESH=0001, PRECHARGE=0010, ACTIVATE=0011, WRITE=0100, READ=0101, STOP=0110, NOP=0111, INHIBIT=1xxx.
REQ-007 Port sdram_a  in  13  row address on ACTIVATE; column A[8:0] and auto-precharge A[10] on READ/WRITE; mode value on LOAD_MODE.
REQ-008 Port sdram_ba  in  2  bank select.
REQ-009 Port sdram_dqml, sdram_dqmh  in  1 each  write byte masks, 1 = byte not written.
REQ-010 Port dq_in  in  16  data from controller.
REQ-011 Port dq_out  out  16  read data to controller.
REQ-012 Port dq_oe  out  1  high while the model drives read data.
REQ-013 Port mode_reg  out  13  last loaded mode register.
REQ-014 Port err  out  1  one-cycle pulse on a protocol violation.
REQ-015 Port err_code  out  3  cause of the last violation; held until the next violation.
REQ-016 Port refresh_cnt  out  16  count of accepted REFRESH commands; wraps at 16'hFFFF.

Function
REQ-017 Commands shall be decoded only when sdram_cke=1 and sdram_ncs=0; INHIBIT and NOP have no effect.
REQ-018 Per-bank state shall be idle/open plus open row; ACTIVATE on an idle bank opens it and records the row and activation edge.
REQ-019 ACTIVATE on an open bank shall set err, err_code=1, and leave the bank state unchanged.
REQ-020 READ/WRITE on an idle bank shall set err with err_code=2; fewer than TRCD edges after ACTIVATE shall set err with err_code=3; a command raising either error shall not be executed.
REQ-021 Word index shall be {BA,row,col[8:0]} truncated to its low MEMW bits.
REQ-022 Burst length shall come from mode_reg[2:0]: 0->1, 1->2, 2->4, 3->8 words; addressing is sequential and wraps within the BL-aligned column block.
REQ-023 CAS latency shall come from mode_reg[6:4]: only 2 and 3 are supported; READ/WRITE with an unsupported CL or BL shall set err with err_code=5 and shall not be executed.
REQ-024 READ sampled at edge E: word k of the burst shall be registered on dq_out with dq_oe=1 at edge E+CL-1+k, so the controller samples it at edge E+CL+k; dq_oe shall return to 0 after the last word.
REQ-025 WRITE sampled at edge E: word k shall be taken from dq_in at edge E+k; the low byte is written only if dqml=0 and the high byte only if dqmh=0.
REQ-026 A new READ/WRITE/STOP/PRECHARGE on the bursting bank shall terminate the running burst; read words already in the CL pipeline shall still be output.
REQ-027 With A[10]=1 on READ/WRITE, the bank shall return to idle on the edge after its last burst word.
REQ-028 PRECHARGE with A[10]=1 shall close all banks; with A[10]=0 it shall close bank BA; precharging an idle bank is legal.
REQ-029 REFRESH and LOAD_MODE with any bank open shall set err with err_code=4 and be ignored; otherwise REFRESH increments refresh_cnt and LOAD_MODE loads mode_reg from sdram_a.
REQ-030 A LOAD_MODE arriving while a read pipeline is pending shall not alter the CL or BL of that read.

Reset
REQ-031 While rst is high: dq_out=0, dq_oe=0, mode_reg=0, err=0, err_code=0, refresh_cnt=0, all banks idle, burst and read pipelines flushed; a reset mid-burst shall drop dq_oe immediately.
REQ-032 Memory contents shall not be reset.

Verification
REQ-033 LOAD_MODE A=13'h0021, ACT row 5, WRITE col 3 with dq_in 16'hA55A then 16'h1234 -> words {5,3}=A55A and {5,2}=1234 (wrap); READ col 3 -> dq_out A55A then 1234 sampled at E+2 and E+3.
REQ-034 Mode BL=1: WRITE 16'hBEEF with dqmh=1 over existing 16'h0000 -> stored 16'h00EF.
REQ-035 READ 1 edge after ACTIVATE with TRCD=2 -> err pulse, err_code=3, dq_oe stays 0.
REQ-036 REFRESH with bank 0 open -> err_code=4 and refresh_cnt unchanged; after PRECHARGE A[10]=1, REFRESH -> refresh_cnt increments by 1.
REQ-037 Mode CL=3, BL=4: READ with A[10]=1 -> 4 words from E+2 to E+5 registered; bank idle afterwards, so a following ACTIVATE raises no error.
REQ-038 Assert rst during a BL=8 read -> dq_oe=0 immediately; after release, READ without ACTIVATE -> err_code=2.
